if_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID pipeline register in the 5-stage RV32I core.
- Owns the PC register and issues single-outstanding requests to instruction memory.
- Applies EX-stage branch/jump redirects and hazard-unit stalls.
- Presents pcd/pc4d/instd plus a bubble flag that drives the IF/ID flush input.

---
 rtl/if_fetch.sv | 185 ++++++++++++++++++
 tb/tb_if_fetch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage feeding the IF/ID register of the RV32I core.
// Owns the PC, keeps at most one instruction-memory request in flight, absorbs
// hazard stalls through a one-entry skid buffer and drops stale responses after
// an EX-stage redirect.
// Optional build macro FETCH_PERF_EN adds the perf_fetched / perf_bubble counters.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pcd,
    output logic [31:0] pc4d,
    output logic [31:0] instd,
    output logic        bubble
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubble
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] inst_q, inst_d;
    logic        pend_q, pend_d;
    logic        bubble_q, bubble_d;
    logic [31:0] redir_tgt;

    // Low two bits of the redirect target are forced to zero.
    assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;

    assign imem_addr = pc_q;
    assign pcd       = pcd_q;
    assign pc4d      = pcd_q + 32'd4;
    assign instd     = bubble_q ? NOP_INST : inst_q;
    assign bubble    = bubble_q;

    // Request valid: a started request is held until its response arrives.
    always_comb begin
        imem_req = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH:   imem_req = pend_q | ~stall;
                HOLD:    imem_req = 1'b0;
                DROP:    imem_req = 1'b1;
                default: imem_req = 1'b0;
            endcase
        end
    end

    // Next-state logic for PC, skid buffer, delivered outputs and FSM.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        pcd_d       = pcd_q;
        inst_d      = inst_q;
        bubble_d    = bubble_q;
        pend_d      = 1'b0;
        if (redirect) begin
            // Redirect beats stall: flush delivered slot and skid.
            bubble_d    = 1'b1;
            skid_pc_d   = 32'd0;
            skid_inst_d = NOP_INST;
            if (imem_req && !imem_rvalid) begin
                // Stale request must still complete; discard it in DROP.
                state_d = DROP;
                tgt_d   = redir_tgt;
                pend_d  = 1'b1;
            end else begin
                state_d = FETCH;
                pc_d    = redir_tgt;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_rvalid) begin
                        pc_d = pc_q + 32'd4;
                        if (!stall) begin
                            pcd_d    = pc_q;
                            inst_d   = imem_rdata;
                            bubble_d = 1'b0;
                        end else begin
                            skid_pc_d   = pc_q;
                            skid_inst_d = imem_rdata;
                            state_d     = HOLD;
                        end
                    end else begin
                        pend_d = imem_req;
                        if (!stall) begin
                            bubble_d = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pcd_d    = skid_pc_q;
                        inst_d   = skid_inst_q;
                        bubble_d = 1'b0;
                        state_d  = FETCH;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        pc_d    = tgt_q;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // Control and delivered-output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            pend_q   <= 1'b0;
            pcd_q    <= 32'd0;
            inst_q   <= NOP_INST;
            bubble_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pend_q   <= pend_d;
            pcd_q    <= pcd_d;
            inst_q   <= inst_d;
            bubble_q <= bubble_d;
        end
    end

    // Redirect target and skid payload; only read after being written.
    always_ff @(posedge clk) begin
        tgt_q       <= tgt_d;
        skid_pc_q   <= skid_pc_d;
        skid_inst_q <= skid_inst_d;
    end

`ifdef FETCH_PERF_EN
    logic        accept;
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_bubble_q;

    assign accept       = (state_q == FETCH) && imem_rvalid && !redirect;
    assign perf_fetched = perf_fetched_q;
    assign perf_bubble  = perf_bubble_q;

    // Free-running wrap-around counters of useful fetches and bubble cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= 32'd0;
            perf_bubble_q  <= 32'd0;
        end else begin
            if (accept) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (bubble_q) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: scoreboard bench for if_fetch with a wait-state memory model.
// Build with FETCH_PERF_EN defined to also check the performance counters.
module tb_if_fetch;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pcd, pc4d, instd;
    logic        bubble;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_bubble;
    int          bub_cnt = 0;
`endif

    if_fetch dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pcd(pcd),
        .pc4d(pc4d), .instd(instd), .bubble(bubble)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_bubble(perf_bubble)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ws      = 0;
    int          cnt     = 0;
    bit          mem_busy = 1'b0;
    bit          drop     = 1'b0;
    bit          in_hold  = 1'b0;
    logic [31:0] held_addr = 32'd0;
    logic [31:0] exp_pc    = 32'd0;
    bit          pv_rst = 1'b0, pv_stall = 1'b0, pv_redir = 1'b0;
    logic [31:0] snap_pcd, snap_inst;
    logic        snap_bub;
    int          del_cnt = 0;
    int          fet_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: check outputs, drive inputs, run the memory model.
    task automatic step(input bit r, input bit s, input bit rd, input logic [31:0] tgt);
        logic rv;
        exp_t e;
        @(negedge clk);
        if (pv_rst) begin
            chk("rst_pcd", pcd, 32'd0);
            chk("rst_pc4d", pc4d, 32'd4);
            chk("rst_inst", instd, NOP);
            chk("rst_bub", 32'(bubble), 32'd1);
        end else if (pv_redir) begin
            chk("redir_bub", 32'(bubble), 32'd1);
            chk("redir_inst", instd, NOP);
        end else if (pv_stall) begin
            chk("stall_pcd", pcd, snap_pcd);
            chk("stall_inst", instd, snap_inst);
            chk("stall_bub", 32'(bubble), 32'(snap_bub));
        end else if (!bubble) begin
            if (sb.size() == 0) begin
                chk("unexp_dlv_sbsize", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("dlv_pcd", pcd, e.pc);
                chk("dlv_pc4d", pc4d, e.pc + 32'd4);
                chk("dlv_inst", instd, e.inst);
                del_cnt++;
            end
        end else begin
            chk("bub_inst", instd, NOP);
        end
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 32'(fet_cnt));
        chk("perf_bubble", perf_bubble, 32'(bub_cnt));
`endif
        snap_pcd  = pcd;
        snap_inst = instd;
        snap_bub  = bubble;

        rst = r; stall = s; redirect = rd; redirect_pc = tgt;
        if (r) begin
            fet_cnt = 0;
            del_cnt = 0;
`ifdef FETCH_PERF_EN
            bub_cnt = 0;
        end else if (bubble) begin
            bub_cnt++;
`endif
        end
        #1;
        rv = 1'b0;
        if (r) begin
            chk("rst_req", 32'(imem_req), 32'd0);
            mem_busy = 1'b0; drop = 1'b0; in_hold = 1'b0;
            exp_pc = 32'd0;
            sb.delete();
        end else begin
            if (mem_busy) begin
                chk("req_busy", 32'(imem_req), 32'd1);
                chk("addr_stable", imem_addr, held_addr);
            end else if (in_hold) begin
                chk("req_hold", 32'(imem_req), 32'd0);
            end else begin
                chk("req", 32'(imem_req), 32'(!s));
            end
            if (imem_req && !mem_busy) begin
                chk("addr", imem_addr, exp_pc);
                mem_busy  = 1'b1;
                held_addr = imem_addr;
                cnt       = ws;
            end
            if (imem_req && mem_busy) begin
                if (cnt == 0) begin
                    rv = 1'b1;
                    mem_busy = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (in_hold && (!s || rd)) in_hold = 1'b0;
            if (rv) begin
                if (rd || drop) begin
                    drop = 1'b0;
                end else begin
                    sb.push_back('{exp_pc, exp_pc ^ KEY});
                    exp_pc = exp_pc + 32'd4;
                    fet_cnt++;
                    if (s) in_hold = 1'b1;
                end
            end
            if (rd) begin
                sb.delete();
                exp_pc = tgt & 32'hFFFF_FFFC;
                if (mem_busy) drop = 1'b1;
            end
        end
        imem_rvalid = rv;
        imem_rdata  = rv ? (held_addr ^ KEY) : 32'hDEAD_BEEF;
        pv_rst = r; pv_stall = s; pv_redir = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        bit found;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        imem_rvalid = 1'b0; imem_rdata = 32'd0;
        @(posedge clk);
        #1 chk("rst_req0", 32'(imem_req), 32'd0);
        @(posedge clk);
        pv_rst = 1'b1;

        // Zero-wait memory: one instruction per cycle.
        ws = 0;
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 0, 32'd0);
            if (i >= 2) chk("zw_bubble", 32'(bubble), 32'd0);
        end

        // Three wait states: one delivery every four cycles.
        ws = 3;
        d0 = del_cnt;
        repeat (20) step(0, 0, 0, 32'd0);
        chk("ws3_rate", 32'(del_cnt - d0), 32'd5);
        repeat (2) step(0, 0, 0, 32'd0);
        step(1, 0, 0, 32'd0);            // reset abandons the in-flight request

        // Stall across a response: skid then release.
        ws = 2;
        step(0, 0, 0, 32'd0);
        repeat (5) step(0, 1, 0, 32'd0);
        repeat (6) step(0, 0, 0, 32'd0);

        // Redirect to 0x100 while the 0x10 request is outstanding.
        step(1, 0, 0, 32'd0);
        ws = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(0, 0, 0, 32'd0);
            found = mem_busy && (held_addr == 32'h10) && (cnt == 2);
        end
        chk("found_0x10", 32'(found), 32'd1);
        step(0, 0, 1, 32'h0000_0100);
        for (int j = 1; j <= 6; j++) begin
            step(0, 0, 0, 32'd0);
            chk("drop_bub", 32'(bubble), 32'd1);
        end
        step(0, 0, 0, 32'd0);
        chk("redir_first_bub", 32'(bubble), 32'd0);
        chk("redir_first_pcd", pcd, 32'h0000_0100);

        // Redirect with stall in the same cycle, then zero-wait redirect.
        ws = 0;
        repeat (3) step(0, 0, 0, 32'd0);
        step(0, 1, 1, 32'h0000_0200);
        repeat (3) step(0, 0, 0, 32'd0);
        step(0, 0, 1, 32'h0000_0300);
        repeat (3) step(0, 0, 0, 32'd0);

        // PC wrap, with an unaligned redirect target.
        step(0, 0, 1, 32'hFFFF_FFFB);
        repeat (3) step(0, 0, 0, 32'd0);
        chk("wrap_pcd", pcd, 32'hFFFF_FFFC);
        chk("wrap_pc4d", pc4d, 32'd0);
        chk("wrap_addr", imem_addr, 32'd0);
        repeat (3) step(0, 0, 0, 32'd0);

        // Quiesce: stall with nothing in flight and drain.
        repeat (3) step(0, 1, 0, 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("fetched_vs_dlv", 32'(del_cnt), 32'(fet_cnt));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
